// File: rtl/ldstr_pkg.sv
// ldstr_pkg
// Shared constants, types and helpers for the ldstr_memory scratch store.
//   LDSTR_DATA_W / LDSTR_ADDR_W / LDSTR_DEPTH : default geometry
//   ldstr_word_t / ldstr_addr_t               : word and address types
//   ldstr_in_range()                          : address bounds check
// Optional build macro used by the top level: LDSTR_VALID_TRACK_EN.
package ldstr_pkg;

  localparam int LDSTR_DATA_W = 32;
  localparam int LDSTR_ADDR_W = 3;
  localparam int LDSTR_DEPTH  = 8;

  typedef logic [LDSTR_DATA_W-1:0] ldstr_word_t;
  typedef logic [LDSTR_ADDR_W-1:0] ldstr_addr_t;

  // True when a zero-extended word address selects an existing entry.
  function automatic logic ldstr_in_range(input logic [31:0] idx,
                                          input int unsigned depth);
    return (idx < depth);
  endfunction

endpackage

// File: rtl/ldstr_mem_array.sv
// ldstr_mem_array
// Storage array with one write port and one registered read port sharing
// a single address. Synchronous active-high reset clears every entry and
// the read register.
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset
//   we_i       write enable (already arbitrated and range-checked)
//   re_i       read enable (already arbitrated)
//   rd_zero_i  force the read result to zero (out-of-range read)
//   addr_i     word address
//   wdata_i    write data
//   rdata_o    registered read data
module ldstr_mem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              rd_zero_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  // No declaration initialisers: power-up zero comes from the target's
  // register init value, and reset clears everything explicitly.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Read register holds unless a read is performed this cycle.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = rd_zero_i ? '0 : mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ldstr_memory.sv
// ldstr_memory
// Small synchronous load/store scratch memory: one write or one read per
// clock, registered read data (1-cycle latency) and a registered
// "access performed" flag.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (wins over any access)
//   ren        load request
//   wen        store request (has priority over ren)
//   addr       word address, direct index, no wrap
//   wdata      store data
//   rdata      registered load data
//   mem_en     registered (ren | wen) of the previous non-reset edge
//   rd_uninit  only with LDSTR_VALID_TRACK_EN: last read hit an entry never
//              written since reset, or an out-of-range address
// Build macro: LDSTR_VALID_TRACK_EN adds per-entry valid bits and rd_uninit.
// There is no handshake: a request is accepted on every edge where it is
// high; the port never stalls.
module ldstr_memory
  import ldstr_pkg::*;
#(
  parameter int DATA_W = LDSTR_DATA_W,
  parameter int ADDR_W = LDSTR_ADDR_W,
  parameter int DEPTH  = LDSTR_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
`ifdef LDSTR_VALID_TRACK_EN
  output logic              mem_en,
  output logic              rd_uninit
`else
  output logic              mem_en
`endif
);

  logic in_range;
  logic wr_go;
  logic rd_go;
  logic mem_en_q;
  logic mem_en_d;

  // Only reachable as false when DEPTH < 2**ADDR_W.
  assign in_range = ldstr_in_range(32'(addr), DEPTH);

  // Write priority: a collision performs the write and drops the read.
  assign wr_go = wen;
  assign rd_go = ren & ~wen;

  ldstr_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (wr_go & in_range),
    .re_i      (rd_go),
    .rd_zero_i (~in_range),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata)
  );

  // Out-of-range accesses still count as performed.
  assign mem_en_d = ren | wen;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q <= 1'b0;
    end else begin
      mem_en_q <= mem_en_d;
    end
  end

  assign mem_en = mem_en_q;

`ifdef LDSTR_VALID_TRACK_EN
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic             rd_uninit_q;
  logic             rd_uninit_d;

  always_comb begin
    valid_d     = valid_q;
    rd_uninit_d = rd_uninit_q;
    if (wr_go && in_range) begin
      valid_d[addr] = 1'b1;
    end
    // An out-of-range read is always reported as uninitialised; the
    // valid bit select is masked by the OR in that case.
    if (rd_go) begin
      rd_uninit_d = ~in_range | ~valid_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      rd_uninit_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rd_uninit_q <= rd_uninit_d;
    end
  end

  assign rd_uninit = rd_uninit_q;
`endif

endmodule

// File: tb/tb_ldstr_memory.sv
// tb_ldstr_memory
// Directed plus randomized bench for ldstr_memory. Two instances share the
// same stimulus: the default geometry (DEPTH=8) and a short one (DEPTH=6)
// so that out-of-range addresses 6 and 7 are exercised.
module tb_ldstr_memory;

  logic        clk;
  logic        rst;
  logic        ren;
  logic        wen;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_en;
  logic [31:0] rdata6;
  logic        mem_en6;
`ifdef LDSTR_VALID_TRACK_EN
  logic        rd_uninit;
  logic        rd_uninit6;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: plain arrays indexed by address.
  logic [31:0] m8 [8];
  logic [31:0] m6 [6];
  bit          v8 [8];
  bit          v6 [6];
  logic [31:0] e_rd;
  logic [31:0] e_rd6;
  logic        e_en;
  logic        e_un;
  logic        e_un6;
  logic [31:0] exp_q [$];

  ldstr_memory u_dut (
    .clk    (clk),
    .rst    (rst),
    .ren    (ren),
    .wen    (wen),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
`ifdef LDSTR_VALID_TRACK_EN
    .mem_en    (mem_en),
    .rd_uninit (rd_uninit)
`else
    .mem_en (mem_en)
`endif
  );

  ldstr_memory #(.DATA_W(32), .ADDR_W(3), .DEPTH(6)) u_dut6 (
    .clk    (clk),
    .rst    (rst),
    .ren    (ren),
    .wen    (wen),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata6),
`ifdef LDSTR_VALID_TRACK_EN
    .mem_en    (mem_en6),
    .rd_uninit (rd_uninit6)
`else
    .mem_en (mem_en6)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m8[i] = '0;
      v8[i] = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      m6[i] = '0;
      v6[i] = 1'b0;
    end
    e_rd  = '0;
    e_rd6 = '0;
    e_en  = 1'b0;
    e_un  = 1'b0;
    e_un6 = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model, check after the edge.
  task automatic step(input logic rs, input logic r, input logic w,
                      input int a, input logic [31:0] d, input string tag);
    @(negedge clk);
    rst   = rs;
    ren   = r;
    wen   = w;
    addr  = 3'(a);
    wdata = d;
    if (rs) begin
      model_clear();
    end else begin
      e_en = r | w;
      if (w) begin
        m8[a] = d;
        v8[a] = 1'b1;
        if (a < 6) begin
          m6[a] = d;
          v6[a] = 1'b1;
        end
      end else if (r) begin
        e_rd  = m8[a];
        e_un  = !v8[a];
        e_rd6 = (a < 6) ? m6[a] : 32'h0;
        e_un6 = (a < 6) ? !v6[a] : 1'b1;
      end
    end
    exp_q.push_back(e_rd);
    @(posedge clk);
    #1;
    check({tag, ".rdata"}, rdata, exp_q.pop_front());
    check({tag, ".mem_en"}, 32'(mem_en), 32'(e_en));
    check({tag, ".rdata6"}, rdata6, e_rd6);
    check({tag, ".mem_en6"}, 32'(mem_en6), 32'(e_en));
`ifdef LDSTR_VALID_TRACK_EN
    check({tag, ".rd_uninit"}, 32'(rd_uninit), 32'(e_un));
    check({tag, ".rd_uninit6"}, 32'(rd_uninit6), 32'(e_un6));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          wr_addr [3];
    logic [31:0] wr_data [3];
    int          rd_addr [4];

    rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
    model_clear();

    // Reset, with requests present that must be ignored.
    step(1'b1, 1'b1, 1'b1, 3, 32'hDEAD_BEEF, "reset");
    for (int a = 0; a < 8; a++) step(1'b0, 1'b1, 1'b0, a, 32'h0, "rd_after_reset");

    // Writes, each held two cycles; rdata must hold.
    wr_addr = '{7, 4, 3};
    wr_data = '{32'hABCD1234, 32'h7676DADE, 32'h98764321};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, wr_addr[i], wr_data[i], "write");
      step(1'b0, 1'b0, 1'b1, wr_addr[i], wr_data[i], "write_hold");
    end

    // Reads back, including a never-written entry.
    rd_addr = '{2, 3, 4, 7};
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, rd_addr[i], 32'h0, "read");

    // Collision: write wins, rdata holds, then read the new value.
    step(1'b0, 1'b1, 1'b1, 5, 32'h11112222, "collision");
    step(1'b0, 1'b1, 1'b0, 5, 32'h0, "read_after_collision");

    // Idle: mem_en drops, rdata holds.
    step(1'b0, 1'b0, 1'b0, 0, 32'h0, "idle");
    step(1'b0, 1'b0, 1'b0, 0, 32'h0, "idle");

    // Reset in the middle of a write burst, then read everything.
    step(1'b0, 1'b0, 1'b1, 0, 32'hCAFE0000, "burst");
    step(1'b0, 1'b0, 1'b1, 1, 32'hCAFE0001, "burst");
    step(1'b1, 1'b0, 1'b1, 2, 32'hCAFE0002, "burst_reset");
    for (int a = 0; a < 8; a++) step(1'b0, 1'b1, 1'b0, a, 32'h0, "rd_after_midreset");

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
           $urandom, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
